// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, prefetches pc_next into a 1-cycle i_mem, resolves EX redirects.
// Optional direct-mapped BTB predictor enabled by defining IF_BTB_EN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_btb_upd,
   input  logic [31:0] i_btb_upd_pc,
   input  logic [31:0] i_btb_upd_target,
   input  logic        i_btb_upd_taken,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic        o_valid,
   output logic        o_pred_taken
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        hit;
   logic [31:0] hit_tgt;

`ifdef IF_BTB_EN
   logic [BTB_ENTRIES-1:0] btb_vld_q;
   logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
   logic [31:0]            btb_tgt_q [BTB_ENTRIES];
   logic [IDX_W-1:0]       lk_idx, up_idx;
   logic [TAG_W-1:0]       lk_tag, up_tag;
   logic                   unused_bits;

   assign lk_idx  = pc_q[IDX_W+1:2];
   assign lk_tag  = pc_q[31:IDX_W+2];
   assign up_idx  = i_btb_upd_pc[IDX_W+1:2];
   assign up_tag  = i_btb_upd_pc[31:IDX_W+2];
   assign hit     = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
   assign hit_tgt = btb_tgt_q[lk_idx];
   assign unused_bits = ^{i_btb_upd_pc[1:0], i_redirect_pc[1:0]};

   // Not-taken only evicts its own entry; an alias sharing the index is left alone.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         btb_vld_q <= '0;
      end else if (i_btb_upd) begin
         if (i_btb_upd_taken)
            btb_vld_q[up_idx] <= 1'b1;
         else if (btb_tag_q[up_idx] == up_tag)
            btb_vld_q[up_idx] <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_btb_upd && i_btb_upd_taken) begin
         btb_tag_q[up_idx] <= up_tag;
         btb_tgt_q[up_idx] <= i_btb_upd_target;
      end
   end
`else
   logic unused_bits;

   assign hit     = 1'b0;
   assign hit_tgt = '0;
   assign unused_bits = ^{i_btb_upd, i_btb_upd_pc, i_btb_upd_target, i_btb_upd_taken,
                          i_redirect_pc[1:0]};
`endif

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (i_redirect)   pc_d = {i_redirect_pc[31:2], 2'b00};
      else if (i_stall) pc_d = pc_q;
      else if (hit)     pc_d = hit_tgt;
      valid_d = (i_stall && !i_redirect) ? valid_q : 1'b1;
   end

   // Reset PC sits one word early so the sequential path prefetches RESET_PC during reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pc_q    <= RESET_PC - 32'd4;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign o_imem_addr  = pc_d;
   assign o_pc         = pc_q;
   assign o_instr      = i_imem_rdata;
   assign o_valid      = valid_q;
   assign o_pred_taken = hit;
endmodule
